// File: rtl/player_ctrl_pkg.sv
// Shared constants and types for the player controller.
package player_ctrl_pkg;

  localparam int unsigned FIELD_W_DEF = 32;
  localparam int unsigned FIELD_H_DEF = 16;
  localparam int unsigned X_W_DEF     = 5;
  localparam int unsigned Y_W_DEF     = 4;
  localparam int unsigned SHIP_ROW    = FIELD_H_DEF - 1;

  // One bullet slot at default playfield geometry.
  typedef struct packed {
    logic               active;
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
  } bullet_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/player_ctrl_button_conditioner.sv
// Two-flop synchroniser, stability debouncer and registered rise pulse for one raw button.
module button_conditioner #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Accept a new level only after it has disagreed with the held level DB_CYCLES clks in a row.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/player_ctrl.sv
// Player controller: conditioned buttons, ship movement, bullet slot pool with cooldown, saturating score.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int unsigned FIELD_W   = FIELD_W_DEF,
  parameter int unsigned FIELD_H   = FIELD_H_DEF,
  parameter int unsigned X_W       = X_W_DEF,
  parameter int unsigned Y_W       = Y_W_DEF,
  parameter int unsigned N_BULLETS = 3,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned COOLDOWN  = 2,
  parameter int unsigned START_X   = FIELD_W / 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_left,
  input  logic                     i_right,
  input  logic                     i_start,
  input  logic                     i_shoot,
  input  logic                     i_score_clear,
  input  logic                     i_enable,
  input  logic [N_BULLETS-1:0]     i_hit,
  output logic [X_W-1:0]           o_pos_ship,
  output logic                     o_start_pulse,
  output logic [N_BULLETS*X_W-1:0] o_bullet_x,
  output logic [N_BULLETS*Y_W-1:0] o_bullet_y,
  output logic [N_BULLETS-1:0]     o_bullet_active,
  output logic                     o_shot_dropped,
  output logic [SCORE_W-1:0]       o_score
);

  localparam int unsigned IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned SUM_W = SCORE_W + 4;

  logic w_rise_l, w_rise_r, w_rise_s, w_rise_sh;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_left  (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_left),  .o_rise(w_rise_l));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_right (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_right), .o_rise(w_rise_r));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_start (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_start), .o_rise(w_rise_s));
  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_shoot (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_shoot), .o_rise(w_rise_sh));

  logic [X_W-1:0]           r_pos;
  logic [N_BULLETS-1:0]     r_act;
  logic [N_BULLETS*X_W-1:0] r_bx;
  logic [N_BULLETS*Y_W-1:0] r_by;
  logic [SCORE_W-1:0]       r_score;
  logic [CD_W-1:0]          r_cool;
  logic                     r_pend_l;
  logic                     r_pend_r;
  logic                     r_start_pulse;
  logic                     r_shot_dropped;

  logic                     w_free_any;
  logic [IDX_W-1:0]         w_free_idx;
  logic                     w_launch;
  logic                     w_drop;
  logic [SUM_W-1:0]         w_score_sum;
  logic [SCORE_W-1:0]       w_score_next;

  // Lowest free slot from pre-update state, launch decision and saturating score sum.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = int'(N_BULLETS) - 1; i >= 0; i--) begin
      if (!r_act[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    w_launch     = w_rise_sh && (r_cool == '0) && w_free_any;
    w_drop       = w_rise_sh && !w_launch;
    w_score_sum  = SUM_W'(r_score) + SUM_W'(popcount8(8'(i_hit & r_act)));
    w_score_next = (w_score_sum[SUM_W-1:SCORE_W] != '0) ? '1 : w_score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos          <= X_W'(START_X);
      r_act          <= '0;
      r_bx           <= '0;
      r_by           <= '0;
      r_score        <= '0;
      r_cool         <= '0;
      r_pend_l       <= 1'b0;
      r_pend_r       <= 1'b0;
      r_start_pulse  <= 1'b0;
      r_shot_dropped <= 1'b0;
    end else begin
      r_start_pulse  <= w_rise_s;
      r_shot_dropped <= w_drop;
      r_score        <= i_score_clear ? '0 : w_score_next;
      if (i_clear) begin
        r_pos    <= X_W'(START_X);
        r_act    <= '0;
        r_bx     <= '0;
        r_by     <= '0;
        r_cool   <= '0;
        r_pend_l <= 1'b0;
        r_pend_r <= 1'b0;
      end else begin
        // A press landing on the tick clk is held over for the following tick.
        if (i_enable) begin
          r_pend_l <= w_rise_l;
          r_pend_r <= w_rise_r;
          if (r_pend_l && !r_pend_r && (r_pos != '0))
            r_pos <= r_pos - X_W'(1);
          else if (r_pend_r && !r_pend_l && (r_pos != X_W'(FIELD_W - 1)))
            r_pos <= r_pos + X_W'(1);
          if (r_cool != '0) r_cool <= r_cool - CD_W'(1);
        end else begin
          r_pend_l <= r_pend_l | w_rise_l;
          r_pend_r <= r_pend_r | w_rise_r;
        end
        if (w_launch) r_cool <= CD_W'(COOLDOWN);
        for (int i = 0; i < int'(N_BULLETS); i++) begin
          if (r_act[i] && i_hit[i]) begin
            r_act[i] <= 1'b0;
          end else if (r_act[i] && i_enable) begin
            if (r_by[i*Y_W +: Y_W] == '0) r_act[i] <= 1'b0;
            else r_by[i*Y_W +: Y_W] <= r_by[i*Y_W +: Y_W] - Y_W'(1);
          end else if (w_launch && (w_free_idx == IDX_W'(i))) begin
            r_act[i]            <= 1'b1;
            r_bx[i*X_W +: X_W]  <= r_pos;
            r_by[i*Y_W +: Y_W]  <= Y_W'(FIELD_H - 2);
          end
        end
      end
    end
  end

  assign o_pos_ship      = r_pos;
  assign o_start_pulse   = r_start_pulse;
  assign o_bullet_x      = r_bx;
  assign o_bullet_y      = r_by;
  assign o_bullet_active = r_act;
  assign o_shot_dropped  = r_shot_dropped;
  assign o_score         = r_score;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed plus random bench for player_ctrl against an event-level model of ship, slots and score.
module tb_player_ctrl;
  import player_ctrl_pkg::*;

  localparam int NB       = 3;
  localparam int XW       = 5;
  localparam int YW       = 4;
  localparam int FW       = 32;
  localparam int COOL     = 2;
  localparam int SMAX     = 255;
  localparam int START_X  = 16;

  logic clk = 1'b0;
  logic reset, clear, left, right, start, shoot, score_clear, enable;
  logic [NB-1:0]    hit;
  logic [XW-1:0]    o_pos_ship;
  logic             o_start_pulse;
  logic [NB*XW-1:0] o_bullet_x;
  logic [NB*YW-1:0] o_bullet_y;
  logic [NB-1:0]    o_bullet_active;
  logic             o_shot_dropped;
  logic [7:0]       o_score;

  always #5 clk = ~clk;

  player_ctrl #(
    .FIELD_W(32), .FIELD_H(16), .X_W(5), .Y_W(4), .N_BULLETS(3),
    .SCORE_W(8), .DB_CYCLES(4), .COOLDOWN(2), .START_X(16)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_left(left), .i_right(right),
    .i_start(start), .i_shoot(shoot), .i_score_clear(score_clear), .i_enable(enable),
    .i_hit(hit), .o_pos_ship(o_pos_ship), .o_start_pulse(o_start_pulse),
    .o_bullet_x(o_bullet_x), .o_bullet_y(o_bullet_y), .o_bullet_active(o_bullet_active),
    .o_shot_dropped(o_shot_dropped), .o_score(o_score)
  );

  int total = 0;
  int bad   = 0;
  int cnt_start = 0, cnt_drop = 0, exp_start = 0, exp_drop = 0;

  // Reference model state
  bullet_t m_slot[NB];
  int      m_pos, m_score, m_cool;
  bit      m_pl, m_pr;

  always @(negedge clk) begin
    if (o_start_pulse === 1'b1)  cnt_start++;
    if (o_shot_dropped === 1'b1) cnt_drop++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pos"}, 32'(o_pos_ship), 32'(m_pos));
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_act%0d", tag, i), 32'(o_bullet_active[i]), 32'(m_slot[i].active));
      if (m_slot[i].active) begin
        chk($sformatf("%s_x%0d", tag, i), 32'(o_bullet_x[i*XW +: XW]), 32'(m_slot[i].x));
        chk($sformatf("%s_y%0d", tag, i), 32'(o_bullet_y[i*YW +: YW]), 32'(m_slot[i].y));
      end
    end
    chk({tag, "_score"}, 32'(o_score), 32'(m_score));
    chk({tag, "_nstart"}, 32'(cnt_start), 32'(exp_start));
    chk({tag, "_ndrop"}, 32'(cnt_drop), 32'(exp_drop));
  endtask

  task automatic model_clear();
    m_pos = START_X; m_cool = 0; m_pl = 0; m_pr = 0;
    for (int i = 0; i < NB; i++) m_slot[i] = '0;
  endtask

  task automatic model_shoot();
    int k;
    k = -1;
    for (int i = NB - 1; i >= 0; i--) if (!m_slot[i].active) k = i;
    if (m_cool == 0 && k >= 0) begin
      m_slot[k].active = 1'b1;
      m_slot[k].x      = XW'(m_pos);
      m_slot[k].y      = YW'(SHIP_ROW - 1);
      m_cool           = COOL;
    end else begin
      exp_drop++;
    end
  endtask

  // Mask bits: 0 left, 1 right, 2 start, 3 shoot.
  task automatic press(input logic [3:0] m, input int hold);
    left = m[0]; right = m[1]; start = m[2]; shoot = m[3];
    step(hold);
    left = 0; right = 0; start = 0; shoot = 0;
    step(10);
    if (m[0]) m_pl = 1;
    if (m[1]) m_pr = 1;
    if (m[2]) exp_start++;
    if (m[3]) model_shoot();
  endtask

  task automatic glitch(input logic [3:0] m);
    left = m[0]; right = m[1]; start = m[2]; shoot = m[3];
    step(2);
    left = 0; right = 0; start = 0; shoot = 0;
    step(10);
  endtask

  task automatic tick();
    enable = 1; step(1); enable = 0; step(2);
    for (int i = 0; i < NB; i++) begin
      if (m_slot[i].active) begin
        if (m_slot[i].y == 0) m_slot[i].active = 1'b0;
        else m_slot[i].y = m_slot[i].y - 1'b1;
      end
    end
    if (m_cool > 0) m_cool--;
    if (m_pl && !m_pr && m_pos > 0) m_pos--;
    if (m_pr && !m_pl && m_pos < FW - 1) m_pos++;
    m_pl = 0; m_pr = 0;
  endtask

  task automatic hit_op(input logic [NB-1:0] mask, input logic sc);
    int add;
    hit = mask; score_clear = sc; step(1); hit = '0; score_clear = 0; step(2);
    add = 0;
    for (int i = 0; i < NB; i++) begin
      if (mask[i] && m_slot[i].active) begin
        add++;
        m_slot[i].active = 1'b0;
      end
    end
    if (sc) m_score = 0;
    else m_score = (m_score + add > SMAX) ? SMAX : m_score + add;
  endtask

  task automatic clear_op();
    clear = 1; step(1); clear = 0; step(2);
    model_clear();
  endtask

  task automatic launch3();
    for (int k = 0; k < 3; k++) begin
      press(4'b1000, 8); tick(); tick();
    end
  endtask

  initial begin
    reset = 1; clear = 0; left = 0; right = 0; start = 0; shoot = 0;
    score_clear = 0; enable = 0; hit = '0;
    model_clear(); m_score = 0;
    step(3);
    reset = 0;
    step(20);
    check_all("reset");
    chk("reset_bx", 32'(o_bullet_x), 32'd0);
    chk("reset_by", 32'(o_bullet_y), 32'd0);

    glitch(4'b0010); tick();        check_all("glitch");
    press(4'b0010, 10); tick();     check_all("right_held");
    press(4'b0011, 8); tick();      check_all("both");
    for (int k = 0; k < 17; k++) begin press(4'b0001, 8); tick(); end
    check_all("left_to0");
    press(4'b0001, 8); tick();      check_all("left_sat0");
    for (int k = 0; k < 31; k++) begin press(4'b0010, 8); tick(); end
    check_all("right_to31");
    press(4'b0010, 8); tick();      check_all("right_sat31");
    clear_op();                     check_all("clear");
    press(4'b0100, 8);              check_all("start");

    press(4'b1000, 8);              check_all("shot0");
    press(4'b1000, 8);              check_all("cool_drop");
    tick(); tick();
    press(4'b1000, 8);              check_all("cool_ok");
    tick(); tick();
    press(4'b1000, 8);              check_all("shot2");
    tick(); tick();
    press(4'b1000, 8);              check_all("full_drop");
    repeat (15) tick();
    check_all("fly_off");

    while (m_score < 252) begin
      launch3();
      hit_op(3'b111, 1'b0);
    end
    check_all("score252");
    launch3();
    hit_op(3'b010, 1'b0);
    press(4'b1000, 8); tick(); tick();
    hit_op(3'b010, 1'b0);           check_all("pre_sat");
    hit_op(3'b101, 1'b0);           check_all("sat");
    press(4'b1000, 8);
    hit_op(3'b001, 1'b1);           check_all("hit_and_clear");

    clear_op();
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: press(4'($urandom_range(1, 15)), 8);
        3:       glitch(4'($urandom_range(1, 15)));
        4, 5, 6: tick();
        7:       hit_op(3'($urandom_range(0, 7)), 1'b0);
        8:       hit_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
        default: if ($urandom_range(0, 3) == 0) clear_op(); else hit_op(3'b000, 1'b1);
      endcase
      check_all($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
